// File: rtl/demux8_sink.sv
// demux8_sink: keyed write-bus sink with a small FIFO toward the local device.
//
// Watches the shared 8-bit-key / 16-bit-data write bus. A valid beat whose key
// equals MULTIPLEX_CODE is pushed into a 2**DEPTH_LOG2-word FIFO. Other keys are
// ignored, so several sinks with distinct codes can share one bus. Buffered
// words are handed to the local device over a valid/ready interface.
//
// Optional feature macro: DEMUX8_SINK_DROP_EN
//   defined   : bus_ready tied 1; matching beats arriving while full are
//               discarded and the sticky overflow flag is set until rst.
//   undefined : bus_ready = !full, nothing is ever dropped, overflow tied 0.
//
// Ports:
//   clk        in   clock, all state on rising edge
//   rst        in   synchronous active-high reset
//   bus_key    in   [7:0]  key of current bus beat
//   bus_data   in   [15:0] data of current bus beat
//   bus_valid  in   beat present this cycle
//   bus_ready  out  sink can accept a matching beat this cycle
//   bus_hit    out  bus_valid && (bus_key == MULTIPLEX_CODE), combinational
//   out_data   out  [15:0] head-of-FIFO word
//   out_valid  out  FIFO non-empty
//   out_ready  in   local device consumes out_data this cycle
//   level      out  [DEPTH_LOG2:0] FIFO occupancy
//   overflow   out  sticky drop flag

module demux8_sink #(
  parameter logic [7:0]  MULTIPLEX_CODE = 8'd0,
  parameter int unsigned DEPTH_LOG2     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            bus_key,
  input  logic [15:0]           bus_data,
  input  logic                  bus_valid,
  output logic                  bus_ready,
  output logic                  bus_hit,
  output logic [15:0]           out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  localparam logic [DEPTH_LOG2-1:0] PtrOne = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   LvlOne = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   LvlMax = (DEPTH_LOG2 + 1)'(Depth);

  logic [15:0]           mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  overflow_q, overflow_d;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic drop;

  assign full    = (level_q == LvlMax);
  assign empty   = (level_q == '0);
  assign bus_hit = bus_valid && (bus_key == MULTIPLEX_CODE);

`ifdef DEMUX8_SINK_DROP_EN
  // Always ready; a hit while full is accepted on the bus but thrown away.
  assign bus_ready = 1'b1;
  assign push      = bus_hit && !full;
  assign drop      = bus_hit && full;
`else
  // Readiness depends on state only, so a same-cycle pop never frees a slot.
  assign bus_ready = !full;
  assign push      = bus_hit && bus_ready;
  assign drop      = 1'b0;
`endif

  assign pop = !empty && out_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end

    unique case ({push, pop})
      2'b10:   level_d = level_q + LvlOne;
      2'b01:   level_d = level_q - LvlOne;
      default: level_d = level_q;
    endcase

    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is cleared on reset so out_data never shows X.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= bus_data;
    end
  end

  assign out_data  = mem_q[rd_ptr_q];
  assign out_valid = !empty;
  assign level     = level_q;

`ifdef DEMUX8_SINK_DROP_EN
  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_demux8_sink.sv
module tb_demux8_sink;

  logic        clk;
  logic        rst;
  logic [7:0]  bus_key;
  logic [15:0] bus_data;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_hit;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  level;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  demux8_sink #(
    .MULTIPLEX_CODE(8'h2A),
    .DEPTH_LOG2    (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus_key  (bus_key),
    .bus_data (bus_data),
    .bus_valid(bus_valid),
    .bus_ready(bus_ready),
    .bus_hit  (bus_hit),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .level    (level),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge; inputs change and outputs are sampled 1 after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] k, input logic [15:0] d);
    bus_key = k; bus_data = d; bus_valid = 1'b1;
    step();
    bus_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus_valid = 1'b1; bus_key = 8'h2A; bus_data = 16'h7777; out_ready = 1'b0;
    step(); step();
    rst = 1'b0; bus_valid = 1'b0;
    #1;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data got %h want 0000", out_data); end
    checks++; if (bus_ready !== 1'b1) begin errors++; $display("FAIL reset_bus_ready got %b want 1", bus_ready); end
    step();
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_nocapture got %0d want 0", level); end
  endtask

  task automatic test_key_filter();
    bus_key = 8'h2B; bus_data = 16'h1111; bus_valid = 1'b1; #1;
    checks++; if (bus_hit !== 1'b0) begin errors++; $display("FAIL filter_hit_miss got %b want 0", bus_hit); end
    step();
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL filter_miss_level got %0d want 0", level); end
    bus_key = 8'h2A; bus_data = 16'hBEEF; #1;
    checks++; if (bus_hit !== 1'b1) begin errors++; $display("FAIL filter_hit got %b want 1", bus_hit); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL filter_no_fallthrough got %b want 0", out_valid); end
    step();
    bus_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL filter_out_valid got %b want 1", out_valid); end
    checks++; if (out_data !== 16'hBEEF) begin errors++; $display("FAIL filter_data got %h want beef", out_data); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL filter_level got %0d want 1", level); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL filter_drain got %0d want 0", level); end
  endtask

  // Back-to-back fill, stall at full, pop frees a slot for the next cycle.
  task automatic test_fill_full();
    for (int i = 1; i <= 4; i++) begin
      bus_key = 8'h2A; bus_data = 16'(i); bus_valid = 1'b1;
      step();
    end
    bus_valid = 1'b0; #1;
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL fill_level got %0d want 4", level); end
    checks++; if (bus_ready !== 1'b0) begin errors++; $display("FAIL fill_bus_ready got %b want 0", bus_ready); end
    checks++; if (out_data !== 16'h0001) begin errors++; $display("FAIL fill_head got %h want 0001", out_data); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_overflow got %b want 0", overflow); end
    bus_key = 8'h2A; bus_data = 16'h0005; bus_valid = 1'b1;
    step(); step();
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL stall_level got %0d want 4", level); end
    out_ready = 1'b1; #1;
    checks++; if (bus_ready !== 1'b0) begin errors++; $display("FAIL stall_pop_ready got %b want 0", bus_ready); end
    step();
    out_ready = 1'b0;
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL stall_pop_level got %0d want 3", level); end
    checks++; if (bus_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_back got %b want 1", bus_ready); end
    step();
    bus_valid = 1'b0;
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL stall_accept got %0d want 4", level); end
    checks++; if (out_data !== 16'h0002) begin errors++; $display("FAIL stall_head got %h want 0002", out_data); end
  endtask

  task automatic test_simul_push_pop();
    out_ready = 1'b1;
    step();
    checks++; if (out_data !== 16'h0003) begin errors++; $display("FAIL order_3 got %h want 0003", out_data); end
    step();
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL simul_pre_level got %0d want 2", level); end
    checks++; if (out_data !== 16'h0004) begin errors++; $display("FAIL order_4 got %h want 0004", out_data); end
    bus_key = 8'h2A; bus_data = 16'h0006; bus_valid = 1'b1;
    step();
    bus_valid = 1'b0;
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL simul_level got %0d want 2", level); end
    checks++; if (out_data !== 16'h0005) begin errors++; $display("FAIL order_5 got %h want 0005", out_data); end
    step();
    checks++; if (out_data !== 16'h0006) begin errors++; $display("FAIL order_6 got %h want 0006", out_data); end
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL simul_empty got %b want 0", out_valid); end
    // Popping while empty must not underflow.
    out_ready = 1'b1; step(); out_ready = 1'b0;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL empty_pop_level got %0d want 0", level); end
  endtask

  task automatic test_reset_mid();
    beat(8'h2A, 16'h00A1); beat(8'h2A, 16'h00A2); beat(8'h2A, 16'h00A3);
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL mid_pre_level got %0d want 3", level); end
    rst = 1'b1; bus_key = 8'h2A; bus_data = 16'hBAD0; bus_valid = 1'b1;
    step();
    rst = 1'b0; bus_valid = 1'b0;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL mid_level got %0d want 0", level); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b want 0", out_valid); end
    beat(8'h2A, 16'hCAFE);
    checks++; if (out_data !== 16'hCAFE) begin errors++; $display("FAIL mid_first_word got %h want cafe", out_data); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL mid_post_level got %0d want 1", level); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

`ifdef DEMUX8_SINK_DROP_EN
  task automatic test_drop();
    for (int i = 0; i < 4; i++) beat(8'h2A, 16'h0010 + 16'(i));
    #1;
    checks++; if (bus_ready !== 1'b1) begin errors++; $display("FAIL drop_ready got %b want 1", bus_ready); end
    beat(8'h2A, 16'hDEAD);
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL drop_level got %0d want 4", level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL drop_overflow got %b want 1", overflow); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_data !== 16'h0010 + 16'(i)) begin
        errors++; $display("FAIL drop_order got %h want %h", out_data, 16'h0010 + 16'(i));
      end
      step();
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drop_empty got %b want 0", out_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL drop_sticky got %b want 1", overflow); end
    rst = 1'b1; step(); rst = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL drop_clear got %b want 0", overflow); end
  endtask
`endif

  initial begin
    rst = 1'b1; bus_key = 8'h00; bus_data = 16'h0000; bus_valid = 1'b0; out_ready = 1'b0;
    #2;
    test_reset();
    test_key_filter();
    test_fill_full();
    test_simul_push_pop();
    test_reset_mid();
`ifdef DEMUX8_SINK_DROP_EN
    test_drop();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux8_sink.md
Name: demux8_sink

Overview:
- Keyed write-side counterpart of the keyed 16-bit read multiplexer chain.
- Snoops the shared 8-bit-key / 16-bit-data write bus. When a valid beat carries a key equal to MULTIPLEX_CODE, it accepts the word into a small FIFO.
- Hands buffered words to the local device over a valid/ready interface.
- Beats with other keys are ignored, so many sinks with distinct codes share one bus.

Parameters:
- MULTIPLEX_CODE, 8'd0: key value this sink answers to.
- DEPTH_LOG2, 2: FIFO depth is 2**DEPTH_LOG2 words (legal range 1..4).

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- rst, input, 1: synchronous active-high reset.
- bus_key, input, 8: key of the current write-bus beat.
- bus_data, input, 16: data of the current write-bus beat.
- bus_valid, input, 1: write-bus beat present this cycle.
- bus_ready, output, 1: sink can accept a matching beat this cycle.
- bus_hit, output, 1: combinational flag, bus_valid && (bus_key == MULTIPLEX_CODE).
- out_data, output, 16: head-of-FIFO word.
- out_valid, output, 1: FIFO non-empty.
- out_ready, input, 1: local device consumes out_data this cycle.
- level, output, DEPTH_LOG2+1: current FIFO occupancy, 0..2**DEPTH_LOG2.
- overflow, output, 1: sticky drop flag (see Optional Feature).

Behaviour:
- Reset, sampled on clk with rst=1: read/write pointers=0, level=0, out_valid=0, overflow=0. out_data is don't-care while out_valid=0 but must not be X after reset; registers clear to 0. rst wins over every simultaneous push/pop, and a beat presented in a reset cycle is discarded.
- Key compare: 8-bit equality, no masking or don't-care bits.
- Push condition: bus_hit && bus_ready.
- Pop condition: out_valid && out_ready.
- bus_ready, baseline build: level != 2**DEPTH_LOG2. It is a function of state only, never of bus_key or bus_valid.
- Non-matching beats never change state, regardless of bus_ready.
- Push: mem[wr_ptr] <= bus_data; wr_ptr increments modulo 2**DEPTH_LOG2 (natural wrap of DEPTH_LOG2-bit pointer).
- Pop: rd_ptr increments modulo 2**DEPTH_LOG2. out_data = mem[rd_ptr] (registered storage, combinational read). A pushed word appears at out_data/out_valid the cycle after the push edge; latency 1 cycle, no fall-through.
- Level update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged; both pointers advance
- Full (level=max): bus_ready=0. A pop in that cycle does not enable a same-cycle push; the push is accepted the next cycle.
- Empty (level=0): out_valid=0, and out_ready is ignored.
- Back-to-back matching beats at full throughput are accepted every cycle while not full.
- The upstream initiator must hold key/data/valid stable until it sees a cycle with bus_hit && bus_ready.

Optional Feature:
- Macro: DEMUX8_SINK_DROP_EN.
- Defined:
  - bus_ready is tied 1.
  - A matching beat arriving while full is discarded: no pointer or level change, and overflow is set.
  - overflow stays 1 until rst.
  - Non-full behaviour is identical to the baseline.
- Undefined:
  - bus_ready = !full as in Behaviour; no beat is ever dropped.
  - overflow is tied 0.

Test Plan:
- Reset and idle: assert rst 2 cycles with bus_valid=1, bus_key=MULTIPLEX_CODE=8'h2A -> level=0, out_valid=0, overflow=0; nothing captured.
- Key filtering: beats key=8'h2B data=16'h1111, then key=8'h2A data=16'hBEEF -> only 16'hBEEF queued, out_valid rises 1 cycle after the 8'h2A edge, level=1.
- Fill to full (DEPTH_LOG2=2): four matching beats 16'h0001..16'h0004 with out_ready=0 -> level=4, bus_ready=0. Fifth beat 16'h0005 held stalls; raising out_ready for one cycle pops 16'h0001; 16'h0005 is accepted the following cycle.
- Simultaneous push/pop at level=2: level stays 2. Order out is 16'h0002, 16'h0003, 16'h0004, 16'h0005 across pointer wrap.
- Reset mid-operation: level=3, then rst pulse with matching beat present -> level=0, out_valid=0; next beat 16'hCAFE is the first word out.
- DROP build: with DEMUX8_SINK_DROP_EN, fill 4 words then send 16'hDEAD -> bus_ready=1, word discarded, overflow=1 and stays 1 after draining; cleared only by rst.
